// File: rtl/circuito_resp_checker_pkg.sv
// Shared types and constants for the circuito response checker.
package circuito_chk_pkg;

  localparam int VEC_W = 9;
  localparam int OUT_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_FINISH = 3'd4
  } chk_state_e;

  // Vector/response part of a log entry; the index width follows CNT_W in the top.
  typedef struct packed {
    logic [VEC_W-1:0] vec;
    logic             x;
    logic             y;
  } log_res_t;

endpackage

// File: rtl/circuito_resp_checker_if.sv
// Vector-source handshake between a ROM/host and the response checker.
interface circuito_resp_checker_if;
  import circuito_chk_pkg::*;

  logic             VEC_VALID;
  logic             VEC_READY;
  logic [VEC_W-1:0] VEC_IN;
  logic             EXP_X;
  logic             EXP_Y;
  logic             VEC_LAST;

  modport master (output VEC_VALID, VEC_IN, EXP_X, EXP_Y, VEC_LAST, input VEC_READY);
  modport slave  (input VEC_VALID, VEC_IN, EXP_X, EXP_Y, VEC_LAST, output VEC_READY);

endinterface

// File: rtl/circuito_resp_checker_log_fifo.sv
// Show-ahead synchronous FIFO for failing-vector records; clr empties it in one cycle.
module chk_log_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int DEPTH = 2 ** AW;

  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push_s, do_pop_s;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop_s  = pop & ~empty & ~clr;
  // A push into a full FIFO is fine when the same cycle frees a slot.
  assign do_push_s = push & (~full | do_pop_s) & ~clr;
  assign dout      = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = {(AW+1){1'b0}};
      rd_d = {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_d = wr_q + (AW+1)'(1);
      else           wr_d = wr_q;
      if (do_pop_s)  rd_d = rd_q + (AW+1)'(1);
      else           rd_d = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/circuito_resp_checker.sv
// Drives stimulus onto circuito, samples X/Y after a settle delay, counts
// vectors and mismatches, and logs failing vectors for readout.
module circuito_resp_checker
  import circuito_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16,
  parameter int LOG_AW        = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  circuito_resp_checker_if.slave       vec,
  output logic [VEC_W-1:0]             DRV,
  input  logic                         X,
  input  logic                         Y,
  output logic                         DONE,
  output logic                         PASS,
  output logic [CNT_W-1:0]             VEC_CNT,
  output logic [CNT_W-1:0]             ERR_CNT,
  input  logic                         LOG_RD,
  output logic                         LOG_EMPTY,
  output logic [CNT_W+VEC_W+OUT_W-1:0] LOG_DATA,
  output logic                         LOG_OVF
);

  localparam int         LOG_W       = CNT_W + VEC_W + OUT_W;
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef struct packed {
    logic [CNT_W-1:0] index;
    log_res_t         res;
  } log_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  chk_state_e       state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [VEC_W-1:0] drv_q, drv_d;
  logic [OUT_W-1:0] exp_q, exp_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d, err_cnt_q, err_cnt_d;
  logic             ovf_q, ovf_d, done_q, done_d, pass_q, pass_d;
  logic             fifo_clr_s, fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic             mismatch_s;
  log_entry_t       entry_s;
  logic [LOG_W-1:0] fifo_dout_s;

  assign fifo_pop_s = LOG_RD & ~fifo_empty_s;
  assign mismatch_s = ({X, Y} != exp_q);
  assign entry_s    = {idx_q, drv_q, X, Y};

  // Next-state and datapath decisions for one vector per pass through the loop.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    drv_d       = drv_q;
    exp_d       = exp_q;
    last_d      = last_q;
    idx_d       = idx_q;
    vec_cnt_d   = vec_cnt_q;
    err_cnt_d   = err_cnt_q;
    ovf_d       = ovf_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fifo_clr_s  = 1'b0;
    fifo_push_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          vec_cnt_d  = {CNT_W{1'b0}};
          err_cnt_d  = {CNT_W{1'b0}};
          ovf_d      = 1'b0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fifo_clr_s = 1'b1;
          state_d    = ST_ACCEPT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCEPT: begin
        if (vec.VEC_VALID) begin
          drv_d    = vec.VEC_IN;
          exp_d    = {vec.EXP_X, vec.EXP_Y};
          last_d   = vec.VEC_LAST;
          idx_d    = vec_cnt_q;
          settle_d = SETTLE_INIT;
          state_d  = ST_SETTLE;
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_SETTLE: begin
        if (settle_q == 4'd0) state_d = ST_SAMPLE;
        else                  settle_d = settle_q - 4'd1;
      end
      ST_SAMPLE: begin
        vec_cnt_d = sat_inc(vec_cnt_q);
        if (mismatch_s) begin
          err_cnt_d = sat_inc(err_cnt_q);
          if (!fifo_full_s || fifo_pop_s) fifo_push_s = 1'b1;
          else                            ovf_d       = 1'b1;
        end else begin
          err_cnt_d = err_cnt_q;
        end
        if (last_q) state_d = ST_FINISH;
        else        state_d = ST_ACCEPT;
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        pass_d  = (err_cnt_q == {CNT_W{1'b0}});
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any run in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      settle_q  <= 4'd0;
      drv_q     <= {VEC_W{1'b0}};
      exp_q     <= {OUT_W{1'b0}};
      last_q    <= 1'b0;
      idx_q     <= {CNT_W{1'b0}};
      vec_cnt_q <= {CNT_W{1'b0}};
      err_cnt_q <= {CNT_W{1'b0}};
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      drv_q     <= drv_d;
      exp_q     <= exp_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  chk_log_fifo #(.DW(LOG_W), .AW(LOG_AW)) u_log (
    .clk   (CLK),
    .rst   (RST),
    .clr   (fifo_clr_s),
    .push  (fifo_push_s),
    .din   (entry_s),
    .pop   (LOG_RD),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  assign vec.VEC_READY = (state_q == ST_ACCEPT);
  assign DRV           = drv_q;
  assign DONE          = done_q;
  assign PASS          = pass_q;
  assign VEC_CNT       = vec_cnt_q;
  assign ERR_CNT       = err_cnt_q;
  assign LOG_OVF       = ovf_q;
  assign LOG_EMPTY     = fifo_empty_s;
  assign LOG_DATA      = fifo_dout_s;

endmodule

// File: tb/tb_circuito_resp_checker.sv
// Randomized and directed bench for circuito_resp_checker with a cycle-timed
// scoreboard model; the bench itself plays the role of circuito.
module tb_circuito_resp_checker;
  import circuito_chk_pkg::*;

  localparam int S     = 3;
  localparam int CW    = 16;
  localparam int DEPTH = 8;
  localparam int LW    = CW + VEC_W + OUT_W;

  logic CLK = 1'b0;
  logic RST = 1'b1, START = 1'b0;
  logic X, Y, DONE, PASS, LOG_EMPTY, LOG_OVF, LOG_RD;
  logic log_rd_man = 1'b0, log_rd_rnd = 1'b0, rnd_en = 1'b0;
  logic y_flip = 1'b0, y_flip_rnd = 1'b0;
  logic [VEC_W-1:0] DRV;
  logic [CW-1:0]    VEC_CNT, ERR_CNT;
  logic [LW-1:0]    LOG_DATA;
  int t = 0, tests = 0, fails = 0;

  circuito_resp_checker_if vif();

  always #5 CLK = ~CLK;
  always @(posedge CLK) t <= t + 1;

  // Stand-in for circuito: X is parity, Y a small AND-OR term.
  function automatic logic cx(input logic [8:0] v); return ^v; endfunction
  function automatic logic cy(input logic [8:0] v); return v[1] | (v[8] & v[7]); endfunction

  assign X      = cx(DRV);
  assign Y      = cy(DRV) ^ y_flip ^ y_flip_rnd;
  assign LOG_RD = log_rd_man | log_rd_rnd;

  circuito_resp_checker #(.SETTLE_CYCLES(S), .CNT_W(CW), .LOG_AW(3)) dut (
    .CLK(CLK), .RST(RST), .START(START), .vec(vif.slave), .DRV(DRV), .X(X), .Y(Y),
    .DONE(DONE), .PASS(PASS), .VEC_CNT(VEC_CNT), .ERR_CNT(ERR_CNT), .LOG_RD(LOG_RD),
    .LOG_EMPTY(LOG_EMPTY), .LOG_DATA(LOG_DATA), .LOG_OVF(LOG_OVF)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, t);
    end
  endtask

  // ---------------- scoreboard model ----------------
  logic          m_on = 1'b0, m_ready, m_done, m_pass, m_ovf, m_run, m_fl, m_fin, fl_last;
  logic [8:0]    m_drv;
  logic [1:0]    fl_exp, obs;
  logic [CW-1:0] m_vc, m_ec, fl_idx;
  int            fl_at, fin_at, e;
  logic [1:0]    hist [64];
  logic [LW-1:0] logq [$];
  logic          run0, rdy0, fl0;

  always @(negedge CLK) begin
    hist[t % 64] = {X, Y};
    if (m_on) begin
      chk("ready", 32'(vif.VEC_READY), 32'(m_ready));
      chk("drv", 32'(DRV), 32'(m_drv));
      chk("done", 32'(DONE), 32'(m_done));
      if (m_done) chk("pass", 32'(PASS), 32'(m_pass));
      chk("vec_cnt", 32'(VEC_CNT), 32'(m_vc));
      chk("err_cnt", 32'(ERR_CNT), 32'(m_ec));
      chk("log_empty", 32'(LOG_EMPTY), 32'(logq.size() == 0));
      chk("log_ovf", 32'(LOG_OVF), 32'(m_ovf));
      if (logq.size() > 0) chk("log_data", 32'(LOG_DATA), 32'(logq[0]));
    end
    // Predict the effect of the coming rising edge number e.
    e = t + 1;
    if (RST) begin
      m_ready = 1'b0; m_drv = 9'd0; m_done = 1'b0; m_pass = 1'b0; m_ovf = 1'b0;
      m_vc = '0; m_ec = '0; m_run = 1'b0; m_fl = 1'b0; m_fin = 1'b0;
      logq.delete();
      m_on = 1'b1;
    end else if (m_on) begin
      run0 = m_run; rdy0 = m_ready; fl0 = m_fl;
      if (LOG_RD && logq.size() > 0) void'(logq.pop_front());
      if (!run0 && START) begin
        m_vc = '0; m_ec = '0; m_ovf = 1'b0; m_done = 1'b0; m_pass = 1'b0;
        logq.delete();
        m_run = 1'b1; m_ready = 1'b1;
      end
      if (rdy0 && vif.VEC_VALID) begin
        m_drv = vif.VEC_IN; fl_exp = {vif.EXP_X, vif.EXP_Y}; fl_last = vif.VEC_LAST;
        fl_idx = m_vc; fl_at = e; m_fl = 1'b1; m_ready = 1'b0;
      end
      if (fl0 && e == fl_at + S + 1) begin
        obs  = hist[(fl_at + S) % 64];
        m_vc = (m_vc == '1) ? m_vc : m_vc + 1'b1;
        if (obs != fl_exp) begin
          m_ec = (m_ec == '1) ? m_ec : m_ec + 1'b1;
          if (logq.size() < DEPTH) logq.push_back({fl_idx, m_drv, obs});
          else                     m_ovf = 1'b1;
        end
        m_fl = 1'b0;
        if (fl_last) begin m_fin = 1'b1; fin_at = e + 1; end
        else m_ready = 1'b1;
      end
      if (m_fin && e == fin_at) begin
        m_done = 1'b1; m_pass = (m_ec == '0); m_run = 1'b0; m_fin = 1'b0;
      end
    end
  end

  // Random log pops and Y glitches during the random phase.
  always @(posedge CLK) begin
    #1;
    log_rd_rnd = rnd_en && ($urandom_range(0, 3) == 0);
    y_flip_rnd = rnd_en && ($urandom_range(0, 7) == 0);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic start_run();
    START = 1'b1; tick(1); START = 1'b0;
  endtask

  task automatic send(input logic [8:0] v, input logic ex, input logic ey, input logic last);
    logic r; int n;
    r = 1'b0; n = 0;
    vif.VEC_IN = v; vif.EXP_X = ex; vif.EXP_Y = ey; vif.VEC_LAST = last; vif.VEC_VALID = 1'b1;
    while (!r && n < 100) begin
      @(negedge CLK); r = vif.VEC_READY;
      @(posedge CLK); #1; n++;
    end
    vif.VEC_VALID = 1'b0;
    if (!r) begin tests++; fails++; $display("FAIL send_timeout: VEC_READY 0 for %0d cycles, expected 1", n); end
  endtask

  task automatic send_rand(input logic mism, input logic last);
    logic [8:0] v; logic [1:0] f;
    v = 9'($urandom);
    f = mism ? 2'($urandom_range(1, 3)) : 2'b00;
    send(v, cx(v) ^ f[1], cy(v) ^ f[0], last);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!DONE && n < 400) begin tick(1); n++; end
    if (!DONE) begin tests++; fails++; $display("FAIL %s: DONE 0 after %0d cycles, expected 1", name, n); end
  endtask

  initial begin
    int lat, nv;
    logic [8:0] v;
    vif.VEC_VALID = 1'b0; vif.VEC_IN = 9'd0; vif.EXP_X = 1'b0; vif.EXP_Y = 1'b0; vif.VEC_LAST = 1'b0;
    RST = 1'b1; tick(3); RST = 1'b0; tick(1);
    chk("rst_ready", 32'(vif.VEC_READY), 32'd0);
    chk("rst_drv", 32'(DRV), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_pass", 32'(PASS), 32'd0);
    chk("rst_cnts", 32'({VEC_CNT, ERR_CNT}), 32'd0);
    chk("rst_log", 32'({LOG_EMPTY, LOG_OVF}), 32'b10);

    // Single passing vector with latency measurement.
    vif.VEC_IN = 9'b001010001; vif.EXP_X = 1'b1; vif.EXP_Y = 1'b0; vif.VEC_LAST = 1'b1;
    vif.VEC_VALID = 1'b1; START = 1'b1; tick(1); START = 1'b0;
    tick(1); vif.VEC_VALID = 1'b0; lat = 1;
    while (!DONE && lat < 50) begin tick(1); lat++; end
    chk("t1_latency", 32'(lat), 32'(S + 3));
    chk("t1_drv", 32'(DRV), 32'h051);
    chk("t1_pass", 32'(PASS), 32'd1);
    chk("t1_cnts", 32'({VEC_CNT, ERR_CNT}), 32'h0001_0000);
    chk("t1_empty", 32'(LOG_EMPTY), 32'd1);

    // Second vector mismatches on Y and is logged with index 1.
    start_run();
    send(9'h003, 1'b0, 1'b1, 1'b0);
    send(9'h0A5, 1'b0, 1'b1, 1'b0);
    send(9'h1C0, 1'b1, 1'b1, 1'b1);
    wait_done("t2_done");
    chk("t2_err", 32'(ERR_CNT), 32'd1);
    chk("t2_pass", 32'(PASS), 32'd0);
    chk("t2_log", 32'(LOG_DATA), 32'({16'd1, 9'h0A5, 2'b00}));
    log_rd_man = 1'b1; tick(1); log_rd_man = 1'b0;
    chk("t2_popped", 32'(LOG_EMPTY), 32'd1);

    // Y glitch just before the sample cycle is ignored, one in it is caught.
    start_run();
    send(9'h051, 1'b1, 1'b0, 1'b1);
    tick(S - 1); y_flip = 1'b1; tick(1); y_flip = 1'b0;
    wait_done("t3a_done");
    chk("t3_early_glitch", 32'(ERR_CNT), 32'd0);
    start_run();
    send(9'h051, 1'b1, 1'b0, 1'b1);
    tick(S); y_flip = 1'b1; tick(1); y_flip = 1'b0;
    wait_done("t3b_done");
    chk("t3_sample_glitch", 32'(ERR_CNT), 32'd1);

    // Ten mismatches overflow an eight-entry log.
    start_run();
    for (int i = 0; i < 10; i++) begin
      v = 9'($urandom);
      send(v, ~cx(v), cy(v), i == 9);
    end
    wait_done("t4_done");
    chk("t4_err", 32'(ERR_CNT), 32'd10);
    chk("t4_ovf", 32'(LOG_OVF), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("t4_idx", 32'(LOG_DATA[LW-1 -: CW]), 32'(k));
      log_rd_man = 1'b1; tick(1); log_rd_man = 1'b0;
    end
    chk("t4_drained", 32'(LOG_EMPTY), 32'd1);

    // One pop mid-run makes room for the ninth mismatch.
    start_run();
    for (int i = 0; i < 8; i++) begin
      v = 9'($urandom);
      send(v, cx(v), ~cy(v), 1'b0);
    end
    tick(S + 2); log_rd_man = 1'b1; tick(1); log_rd_man = 1'b0;
    v = 9'($urandom);
    send(v, ~cx(v), cy(v), 1'b1);
    wait_done("t4b_done");
    chk("t4b_ovf", 32'(LOG_OVF), 32'd0);
    chk("t4b_err", 32'(ERR_CNT), 32'd9);
    chk("t4b_head", 32'(LOG_DATA[LW-1 -: CW]), 32'd1);

    // Backpressure in ACCEPT and an ignored mid-run START.
    start_run();
    send(9'h0F0, cx(9'h0F0), cy(9'h0F0), 1'b0);
    tick(S + 3); tick(5);
    chk("t5_hold_cnt", 32'(VEC_CNT), 32'd1);
    chk("t5_hold_drv", 32'(DRV), 32'h0F0);
    send(9'h10F, cx(9'h10F), cy(9'h10F), 1'b0);
    tick(1); START = 1'b1; tick(1); START = 1'b0;
    send(9'h055, cx(9'h055), cy(9'h055), 1'b1);
    wait_done("t5_done");
    chk("t5_cnt", 32'(VEC_CNT), 32'd3);
    chk("t5_pass", 32'(PASS), 32'd1);

    // Reset during SETTLE of the third vector.
    start_run();
    send(9'h011, cx(9'h011), cy(9'h011), 1'b0);
    send(9'h122, ~cx(9'h122), cy(9'h122), 1'b0);
    send(9'h033, cx(9'h033), cy(9'h033), 1'b0);
    tick(1); RST = 1'b1; tick(1); RST = 1'b0;
    chk("t6_ready", 32'(vif.VEC_READY), 32'd0);
    chk("t6_drv", 32'(DRV), 32'd0);
    chk("t6_flags", 32'({DONE, PASS, LOG_OVF, LOG_EMPTY}), 32'b0001);
    chk("t6_cnts", 32'({VEC_CNT, ERR_CNT}), 32'd0);
    start_run();
    send(9'h1FF, cx(9'h1FF), cy(9'h1FF), 1'b1);
    wait_done("t6_done");
    chk("t6_recount", 32'(VEC_CNT), 32'd1);

    // Random runs with gaps, stray STARTs, random pops and Y glitches.
    rnd_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      start_run();
      nv = $urandom_range(3, 12);
      for (int i = 0; i < nv; i++) begin
        tick($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) begin START = 1'b1; tick(1); START = 1'b0; end
        send_rand($urandom_range(0, 2) == 0, i == nv - 1);
      end
      wait_done("rnd_done");
      tick($urandom_range(0, 4));
    end
    rnd_en = 1'b0;
    tick(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/circuito_resp_checker.md
Name: circuito_resp_checker

Overview:
- Sequential response-side harness for the combinational block `circuito`, which has inputs A..I and outputs X, Y.
- Accepts stimulus vectors with expected outputs over a valid/ready handshake and drives A..I onto the circuit. After a settle delay it samples X/Y and compares them with the expected values.
- Counts vectors and mismatches, and logs each failing vector in a small FIFO for readout.
- Sits between a vector source (ROM or host) and `circuito` in on-board self-test builds.

Parameters:
- SETTLE_CYCLES, 2: clock cycles between driving DRV and sampling X/Y (allowed range 1..15).
- CNT_W, 16: width of the vector and error counters.
- LOG_AW, 3: log FIFO address width; depth = 2**LOG_AW = 8 entries.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; clears counters and log, then begins a run.
- VEC_VALID  in  1  source presents a vector.
- VEC_READY  out  1  checker accepts the vector this cycle.
- VEC_IN  in  9  stimulus; bit8=A, bit7=B … bit0=I.
- EXP_X  in  1  expected X for VEC_IN.
- EXP_Y  in  1  expected Y for VEC_IN.
- VEC_LAST  in  1  marks the final vector of the run.
- DRV  out  9  registered drive to circuito A..I, same bit order as VEC_IN.
- X  in  1  circuit output X.
- Y  in  1  circuit output Y.
- DONE  out  1  high from run completion until the next START or RST.
- PASS  out  1  valid while DONE; 1 iff ERR_CNT==0.
- VEC_CNT  out  CNT_W  vectors checked.
- ERR_CNT  out  CNT_W  mismatching vectors.
- LOG_RD  in  1  pop one log entry.
- LOG_EMPTY  out  1  log FIFO empty.
- LOG_DATA  out  CNT_W+11  head entry, {index[CNT_W-1:0], VEC_IN[8:0], X, Y}.
- LOG_OVF  out  1  sticky; a mismatch occurred while the log was full.

Behaviour:
- Reset values:
  - State IDLE.
  - VEC_READY=0, DRV=0, DONE=0, PASS=0, VEC_CNT=0, ERR_CNT=0, LOG_OVF=0, LOG_EMPTY=1.
  - LOG_DATA is don't-care while LOG_EMPTY=1.
  - Reset aborts any run in progress immediately. No partial count or log write survives.
- FSM states: IDLE, ACCEPT, SETTLE, SAMPLE, FINISH.
  - IDLE: START → clear VEC_CNT, ERR_CNT, log pointers, LOG_OVF and DONE; go to ACCEPT. START in any other state is ignored.
  - ACCEPT: VEC_READY=1. On VEC_VALID&VEC_READY:
    - DRV<=VEC_IN next edge.
    - Latch EXP_X, EXP_Y, VEC_LAST and the current VEC_CNT (as the index).
    - Load the settle counter with SETTLE_CYCLES-1; go to SETTLE.
    - VEC_READY is combinational from state only, never from VEC_VALID.
  - SETTLE: decrement the counter each cycle; at 0 go to SAMPLE.
    - Result: X/Y are sampled exactly SETTLE_CYCLES cycles after the DRV update edge.
    - VEC_READY=0.
  - SAMPLE: compare {X,Y} with the latched {EXP_X,EXP_Y}; VEC_CNT += 1.
    - On mismatch: ERR_CNT += 1 (saturate at all-ones). Push {index, DRV, X, Y} to the log if not full; if full, set LOG_OVF and drop the entry.
    - If the latched LAST=1 go to FINISH, else go to ACCEPT.
    - VEC_CNT saturates at all-ones. The logged index is the pre-increment VEC_CNT value.
  - FINISH: DONE=1, PASS=(ERR_CNT==0); go to IDLE on the same edge. DONE stays high in IDLE until START or RST.
- Throughput: one vector every SETTLE_CYCLES+2 cycles.
- DRV holds its last value between vectors and after DONE.
- Log FIFO:
  - Show-ahead: LOG_DATA is valid whenever LOG_EMPTY=0.
  - LOG_RD while empty is ignored.
  - A simultaneous push and pop when full is allowed: both happen, the count stays the same, and LOG_OVF is not set.
  - Pointers wrap modulo depth; an extra pointer bit distinguishes full from empty.
- LOG_RD is honoured in every state, including during a run and after DONE.

Decomposition:
- Package `circuito_chk_pkg`:
  - State enum.
  - Log entry struct {index, vec, x, y}.
  - Constants VEC_W=9 and OUT_W=2.
- Sub-module `chk_log_fifo`: parameterised synchronous FIFO with show-ahead output and full/empty flags. Instantiated once.

Test Plan:
- Single pass: RST, START, one vector VEC_IN=9'b001010001 with VEC_LAST=1, model X=EXP_X=1, Y=EXP_Y=0 → DRV=9'h051; DONE after 1+SETTLE_CYCLES+2 cycles; PASS=1, VEC_CNT=1, ERR_CNT=0, LOG_EMPTY=1.
- Mismatch logging: 3 vectors, the 2nd with EXP_Y≠Y → ERR_CNT=1, PASS=0; LOG_DATA index=1 with that vector and the observed X,Y. After LOG_RD, LOG_EMPTY=1.
- Sampling time: the model changes Y one cycle before the sample point versus at the sample point with SETTLE_CYCLES=3 → only the value present at DRV-edge+3 is compared.
- Log overflow: 10 consecutive mismatching vectors, depth 8 → ERR_CNT=10, 8 entries logged with indices 0..7, LOG_OVF=1. Popping once during the run makes room for the next mismatch.
- Backpressure: hold VEC_VALID low for 5 cycles in ACCEPT → no count change, DRV unchanged. START asserted mid-run is ignored.
- Reset mid-run: assert RST in SETTLE after 2 vectors → all outputs return to reset values. A new START run counts from 0.
